// File: rtl/counter_bank.sv
// counter_bank: a bank of saturating, monotonic counters served one command
// at a time through a valid/ready command port and a valid/ready response port.
// Each command walks IDLE -> EXEC -> RESP, so the peak rate is one command
// every three cycles.
module counter_bank #(
   parameter int NUM_COUNTERS = 4,
   parameter int WIDTH        = 32,
   parameter int ARG_WIDTH    = 8,
   localparam int IDX_BITS    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [IDX_BITS-1:0]  cmd_idx,
   input  logic [ARG_WIDTH-1:0] cmd_arg,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_value,
   output logic [1:0]           rsp_status
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_INCR = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_SAT     = 2'b01;
   localparam logic [1:0] ST_BAD_IDX = 2'b10;
   localparam logic [1:0] ST_BAD_OP  = 2'b11;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [31:0]      NUM_C   = NUM_COUNTERS;

   // FSM and latched-command registers
   state_t               state_q, state_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]     rsp_value_q, rsp_value_d;
   logic [1:0]           rsp_status_q, rsp_status_d;
   logic [1:0]           op_q, op_d;
   logic [IDX_BITS-1:0]  idx_q, idx_d;
   logic [ARG_WIDTH-1:0] arg_q, arg_d;

   // Counter values gathered from the per-counter generate blocks
   logic [WIDTH-1:0] cnt_vals [NUM_COUNTERS];

   // Execution datapath
   logic             idx_ok;
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH:0]   inc_ext;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] new_val;
   logic [1:0]       new_status;
   logic             do_write;

   // The index port may be wider than needed when NUM_COUNTERS is not a power of two
   assign idx_ok = (32'(idx_q) < NUM_C);

   // Select the addressed counter with a compare-mux so out-of-range indices read as 0
   always_comb begin
      cur_val = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (idx_q == IDX_BITS'(i)) begin
            cur_val = cnt_vals[i];
         end
      end
   end

   // Saturating add on a WIDTH+1 bit sum; error cases report value 0 and never write
   always_comb begin
      inc_ext    = '0;
      sum        = '0;
      new_val    = '0;
      new_status = ST_OK;
      do_write   = 1'b0;
      case (op_q)
         OP_INCR: inc_ext = (WIDTH+1)'(1);
         OP_ADD:  inc_ext = (WIDTH+1)'(arg_q);
         default: inc_ext = '0;
      endcase
      sum = {1'b0, cur_val} + inc_ext;
      if (!idx_ok) begin
         new_status = ST_BAD_IDX;
      end else if (op_q == OP_RSVD) begin
         new_status = ST_BAD_OP;
      end else if (sum[WIDTH]) begin
         // Covers both a fresh overflow and a nonzero increment applied at max
         new_val    = CNT_MAX;
         new_status = ST_SAT;
         do_write   = 1'b1;
      end else begin
         new_val    = sum[WIDTH-1:0];
         new_status = ST_OK;
         do_write   = (op_q != OP_READ);
      end
   end

   // One register per counter, written only by an in-range EXEC aimed at it
   for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
      logic [WIDTH-1:0] cnt_q, cnt_d;

      // Next value: hold unless this counter is the target of the executing op
      always_comb begin
         cnt_d = cnt_q;
         if ((state_q == S_EXEC) && do_write && (idx_q == IDX_BITS'(gi))) begin
            cnt_d = new_val;
         end
      end

      // Counter storage, cleared by reset
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_vals[gi] = cnt_q;
   end

   // Next-state and registered-output logic of the command FSM
   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_value_d  = rsp_value_q;
      rsp_status_d = rsp_status_q;
      op_d         = op_q;
      idx_d        = idx_q;
      arg_d        = arg_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d        = cmd_op;
               idx_d       = cmd_idx;
               arg_d       = cmd_arg;
               cmd_ready_d = 1'b0;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_value_d  = new_val;
            rsp_status_d = new_status;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            // Response is held until the consumer takes it
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   // FSM state, latched command and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_value_q  <= '0;
         rsp_status_q <= ST_OK;
         op_q         <= OP_READ;
         idx_q        <= '0;
         arg_q        <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_value_q  <= rsp_value_d;
         rsp_status_q <= rsp_status_d;
         op_q         <= op_d;
         idx_q        <= idx_d;
         arg_q        <= arg_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_value  = rsp_value_q;
   assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank with 3 counters of 8 bits.
// The driver pushes the expected response (and handshake cycle) at each
// command handshake; a monitor pops and compares whenever a response is taken.
module tb_counter_bank;

   localparam int NC = 3;
   localparam int W  = 8;
   localparam int AW = 8;
   localparam int IB = 2;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_INCR = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam int ST_OK      = 0;
   localparam int ST_SAT     = 1;
   localparam int ST_BAD_IDX = 2;
   localparam int ST_BAD_OP  = 3;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op    = 2'b00;
   logic [IB-1:0] cmd_idx   = '0;
   logic [AW-1:0] cmd_arg   = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [W-1:0]  rsp_value;
   logic [1:0]    rsp_status;

   counter_bank #(
      .NUM_COUNTERS(NC),
      .WIDTH(W),
      .ARG_WIDTH(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_idx(cmd_idx),
      .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_value(rsp_value),
      .rsp_status(rsp_status)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [W-1:0] val;
      logic [1:0]   st;
      int           hs;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: latency check on each rising rsp_valid, value/status check on each accept
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!reset) begin
         if (rsp_valid && !prev_valid) begin
            if (sb_q.size() == 0) chk("unexpected_rsp", 1, 0);
            else                  chk("rsp_latency", cycle - sb_q[0].hs, 1);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_accept", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_value", rsp_value, e.val);
               chk("rsp_status", rsp_status, e.st);
               $display("rsp: value=%0d status=%0d (expected %0d/%0d)", rsp_value, rsp_status, e.val, e.st);
            end
         end
      end
      prev_valid = rsp_valid;
   end

   // Issue one command (called at a falling edge); returns the handshake cycle
   task automatic send(input logic [1:0] op, input int idx, input int arg,
                       input int ev, input int es, output int hs);
      int waited = 0;
      hs        = -1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = IB'(idx);
      cmd_arg   = AW'(arg);
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      hs = cycle + 1;
      sb_q.push_back('{val: W'(ev), st: 2'(es), hs: hs});
      $display("cmd: op=%0d idx=%0d arg=%0d expect %0d/%0d", op, idx, arg, ev, es);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Wait until every pushed response has been taken
   task automatic drain();
      int w = 0;
      while ((sb_q.size() != 0 || rsp_valid) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", sb_q.size(), 0);
   endtask

   int h1, h2, h3, hd;

   initial begin
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_value", rsp_value, 0);
      chk("rst_rsp_status", rsp_status, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: READ after reset
      send(OP_READ, 0, 0, 0, ST_OK, hd);
      drain();

      // 2: three back-to-back INCRs, then neighbours untouched
      send(OP_INCR, 1, 0, 1, ST_OK, h1);
      send(OP_INCR, 1, 0, 2, ST_OK, h2);
      send(OP_INCR, 1, 0, 3, ST_OK, h3);
      chk("cmd_spacing_1", h2 - h1, 3);
      chk("cmd_spacing_2", h3 - h2, 3);
      send(OP_READ, 0, 0, 0, ST_OK, hd);
      send(OP_READ, 2, 0, 0, ST_OK, hd);
      send(OP_READ, 3, 0, 0, ST_BAD_IDX, hd);
      drain();

      // 3: saturation
      send(OP_ADD, 2, 200, 200, ST_OK, hd);
      send(OP_ADD, 2, 100, 255, ST_SAT, hd);
      send(OP_INCR, 2, 0, 255, ST_SAT, hd);
      send(OP_ADD, 2, 0, 255, ST_OK, hd);
      drain();

      // 4: errors, BAD_IDX outranks BAD_OP, counters unchanged
      send(OP_INCR, 3, 0, 0, ST_BAD_IDX, hd);
      send(OP_RSVD, 0, 0, 0, ST_BAD_OP, hd);
      send(OP_RSVD, 3, 0, 0, ST_BAD_IDX, hd);
      send(OP_READ, 0, 0, 0, ST_OK, hd);
      send(OP_READ, 1, 0, 3, ST_OK, hd);
      send(OP_READ, 2, 0, 255, ST_OK, hd);
      drain();

      // 5: back-pressure on the response; a new command must be ignored
      rsp_ready = 1'b0;
      send(OP_INCR, 1, 0, 4, ST_OK, hd);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         cmd_valid = 1'b1;
         cmd_op    = OP_INCR;
         cmd_idx   = 2'd0;
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_value", rsp_value, 4);
         chk("hold_rsp_status", rsp_status, ST_OK);
         chk("hold_cmd_ready", cmd_ready, 0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();
      send(OP_READ, 0, 0, 0, ST_OK, hd);
      send(OP_READ, 1, 0, 4, ST_OK, hd);
      drain();

      // 6: reset during EXEC of INCR idx 0 (prior value 7)
      send(OP_ADD, 0, 7, 7, ST_OK, hd);
      drain();
      send(OP_INCR, 0, 0, 8, ST_OK, hd);
      chk("exec_cmd_ready", cmd_ready, 0);
      reset = 1'b1;
      #1;
      chk("async_rst_cmd_ready", cmd_ready, 1);
      chk("async_rst_rsp_valid", rsp_valid, 0);
      chk("async_rst_rsp_value", rsp_value, 0);
      chk("async_rst_rsp_status", rsp_status, 0);
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(OP_READ, 0, 0, 0, ST_OK, hd);
      send(OP_READ, 1, 0, 0, ST_OK, hd);
      send(OP_READ, 2, 0, 0, ST_OK, hd);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
